// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/memory bus arbiter: FSM states, bus owner
// encoding, timeout counter width and a sizing helper for the burst counter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

    localparam int unsigned TO_W = 8;

    // Bits needed to hold the values 0..n.
    function automatic int unsigned burst_cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Fairness helper: data normally wins the bus, but after DATA_BURST data
// grants in a row while a fetch was waiting, the fetch wins once.
module mem_port_arbiter_starve_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic if_req_i,
    input  logic mem_req_i,
    output logic grant_if_o,
    output logic grant_mem_o
);

    localparam int unsigned    CNT_W   = burst_cnt_w(DATA_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_BURST);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fetch_turn;

    // Grant decision and next burst count.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d       = cnt_q;
        fetch_turn  = if_req_i && (cnt_q == CNT_MAX);
        grant_mem_o = mem_req_i && !fetch_turn;
        grant_if_o  = if_req_i && !grant_mem_o;

        if (!if_req_i) begin
            cnt_d = '0;
        end else if (arb_en && grant_if_o) begin
            cnt_d = '0;
        end else if (arb_en && grant_mem_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Burst counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between instruction
// fetch and the data stage. Commands are registered one cycle after
// selection; ready pulses come combinationally off bus_rvalid_i.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DATA_BURST = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ready_o,
    input  logic                if_flush_i,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [DATA_W/8-1:0] mem_wstrb_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ready_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_wstrb_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    output logic                F_stall_req_o,
    output logic                M_stall_req_o,
    output logic                err_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic                bus_req_q,   bus_req_d;
    logic                bus_we_q,    bus_we_d;
    logic [DATA_W/8-1:0] bus_wstrb_q, bus_wstrb_d;
    logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [TO_W-1:0]     to_cnt_q,    to_cnt_d;
    logic                err_q,       err_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    logic arb_en;
    logic grant_if;
    logic grant_mem;
    logic fetch_kill;
    logic if_ready;
    logic mem_ready;

    mem_port_arbiter_starve_cnt #(
        .DATA_BURST (DATA_BURST)
    ) u_starve_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_en      (arb_en),
        .if_req_i    (if_req_i),
        .mem_req_i   (mem_req_i),
        .grant_if_o  (grant_if),
        .grant_mem_o (grant_mem)
    );

    // Next-state, command capture, timeout and ready generation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
        arb_en      = 1'b0;
        if_ready    = 1'b0;
        mem_ready   = 1'b0;
        fetch_kill  = (owner_q == OWN_IF) && if_flush_i;

        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
                if (grant_mem) begin
                    state_d     = ST_REQ;
                    owner_d     = OWN_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_wstrb_d = mem_wstrb_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                end else if (grant_if) begin
                    state_d     = ST_REQ;
                    owner_d     = OWN_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_wstrb_d = '0;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                end
            end

            ST_REQ: begin
                if (bus_gnt_i) begin
                    // An accepted command must be drained even if its fetch was killed.
                    bus_req_d = 1'b0;
                    to_cnt_d  = '0;
                    if (fetch_kill) begin
                        state_d = ST_DROP;
                        owner_d = OWN_NONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (fetch_kill) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_IDLE;
                    owner_d   = OWN_NONE;
                end
            end

            ST_WAIT: begin
                if (bus_rvalid_i) begin
                    mem_ready = (owner_q == OWN_MEM);
                    if_ready  = (owner_q == OWN_IF) && !if_flush_i;
                    state_d   = ST_IDLE;
                    owner_d   = OWN_NONE;
                    to_cnt_d  = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    // Give up without a ready pulse; the stage keeps stalling.
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                    owner_d  = OWN_NONE;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (fetch_kill) begin
                        state_d = ST_DROP;
                        owner_d = OWN_NONE;
                    end
                end
            end

            ST_DROP: begin
                if (bus_rvalid_i) begin
                    state_d  = ST_IDLE;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        if_rdata_d  = if_ready  ? bus_rdata_i : if_rdata_q;
        mem_rdata_d = mem_ready ? bus_rdata_i : mem_rdata_q;
    end

    // State and registered bus command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_wstrb_q <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_wstrb_o   = bus_wstrb_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign err_o         = err_q;
    assign if_ready_o    = if_ready;
    assign mem_ready_o   = mem_ready;
    assign if_rdata_o    = if_rdata_d;
    assign mem_rdata_o   = mem_rdata_d;
    assign F_stall_req_o = if_req_i & ~if_ready;
    assign M_stall_req_o = mem_req_i & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, data/fetch fairness,
// delayed-grant store, fetch flush, timeout and asynchronous reset.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;
    logic              if_flush_i = 1'b0;
    logic              mem_req_i = 1'b0;
    logic              mem_we_i = 1'b0;
    logic [3:0]        mem_wstrb_i = '0;
    logic [ADDR_W-1:0] mem_addr_i = '0;
    logic [DATA_W-1:0] mem_wdata_i = '0;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_ready_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [3:0]        bus_wstrb_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_gnt_i = 1'b0;
    logic              bus_rvalid_i = 1'b0;
    logic [DATA_W-1:0] bus_rdata_i = '0;
    logic              F_stall_req_o;
    logic              M_stall_req_o;
    logic              err_o;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DATA_BURST (4),
        .TIMEOUT    (255)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_rdata_o    (if_rdata_o),
        .if_ready_o    (if_ready_o),
        .if_flush_i    (if_flush_i),
        .mem_req_i     (mem_req_i),
        .mem_we_i      (mem_we_i),
        .mem_wstrb_i   (mem_wstrb_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_rdata_o   (mem_rdata_o),
        .mem_ready_o   (mem_ready_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_wstrb_o   (bus_wstrb_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_gnt_i     (bus_gnt_i),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i),
        .F_stall_req_o (F_stall_req_o),
        .M_stall_req_o (M_stall_req_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Serve one bus transaction with immediate grant and response; report who got ready.
    task automatic serve_one(output logic [31:0] a, output logic ri, output logic rm);
        int n;
        n  = 0;
        ri = 1'b0;
        rm = 1'b0;
        a  = '0;
        sample();
        while (!bus_req_o && n < 20) begin
            next_cycle();
            sample();
            n++;
        end
        if (bus_req_o) begin
            a         = bus_addr_o;
            bus_gnt_i = 1'b1;
            next_cycle();
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = a ^ 32'hA5A5_0000;
            sample();
            ri = if_ready_o;
            rm = mem_ready_o;
            next_cycle();
            bus_rvalid_i = 1'b0;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got_addr;
        logic        got_if;
        logic        got_mem;
        logic        ready_seen;
        bit          exp_mem [6];
        exp_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        sample();
        check("rst_bus_req", 128'(bus_req_o), 128'(1'b0));
        check("rst_err", 128'(err_o), 128'(1'b0));
        check("rst_readys", 128'({if_ready_o, mem_ready_o}), 128'(2'b00));
        check("rst_bus_fields", 128'({bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o}), 128'(0));
        rst_n = 1'b1;
        next_cycle();

        // ---------------- single fetch, immediate gnt/rvalid ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        sample();
        check("f_c0_stall", 128'(F_stall_req_o), 128'(1'b1));
        check("f_c0_bus_req", 128'(bus_req_o), 128'(1'b0));
        next_cycle();
        bus_gnt_i = 1'b1;
        sample();
        check("f_c1_cmd", 128'({bus_req_o, bus_we_o, bus_addr_o}), 128'({1'b1, 1'b0, 32'h100}));
        check("f_c1_stall", 128'(F_stall_req_o), 128'(1'b1));
        next_cycle();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h0000_0013;
        sample();
        check("f_c2_ready", 128'(if_ready_o), 128'(1'b1));
        check("f_c2_rdata", 128'(if_rdata_o), 128'(32'h13));
        check("f_c2_stall", 128'(F_stall_req_o), 128'(1'b0));
        check("f_c2_bus_req", 128'(bus_req_o), 128'(1'b0));
        next_cycle();
        bus_rvalid_i = 1'b0;
        if_req_i     = 1'b0;
        sample();
        check("f_c3_ready_low", 128'(if_ready_o), 128'(1'b0));

        // ---------------- fairness: both request continuously ----------------
        next_cycle();
        if_req_i   = 1'b1;
        if_addr_i  = 32'h400;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h800;
        for (int i = 0; i < 6; i++) begin
            serve_one(got_addr, got_if, got_mem);
            check($sformatf("burst_%0d_addr", i), 128'(got_addr),
                  128'(exp_mem[i] ? 32'h800 : 32'h400));
            check($sformatf("burst_%0d_mem_ready", i), 128'(got_mem), 128'(exp_mem[i]));
            check($sformatf("burst_%0d_if_ready", i), 128'(got_if), 128'(!exp_mem[i]));
        end
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        next_cycle();

        // ---------------- store with delayed grant ----------------
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = 32'h2000;
        mem_wdata_i = 32'hDEAD_BEEF;
        mem_wstrb_i = 4'h3;
        sample();
        check("st_c0_stall", 128'(M_stall_req_o), 128'(1'b1));
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            sample();
            check($sformatf("st_hold_%0d", i),
                  128'({bus_req_o, bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o}),
                  128'({1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF}));
            check($sformatf("st_hold_%0d_ready", i), 128'(mem_ready_o), 128'(1'b0));
            if (i == 4) bus_gnt_i = 1'b1;
            next_cycle();
        end
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        sample();
        check("st_ack_ready", 128'(mem_ready_o), 128'(1'b1));
        check("st_ack_stall", 128'(M_stall_req_o), 128'(1'b0));
        check("st_ack_bus_req", 128'(bus_req_o), 128'(1'b0));
        next_cycle();
        bus_rvalid_i = 1'b0;
        mem_req_i    = 1'b0;
        mem_we_i     = 1'b0;
        sample();
        check("st_after_ready", 128'(mem_ready_o), 128'(1'b0));

        // ---------------- fetch flushed in WAIT ----------------
        next_cycle();
        if_req_i  = 1'b1;
        if_addr_i = 32'h300;
        next_cycle();
        bus_gnt_i = 1'b1;
        sample();
        check("fl_cmd_addr", 128'(bus_addr_o), 128'(32'h300));
        next_cycle();
        bus_gnt_i  = 1'b0;
        if_flush_i = 1'b1;
        sample();
        check("fl_wait_ready", 128'(if_ready_o), 128'(1'b0));
        next_cycle();
        if_flush_i   = 1'b0;
        if_addr_i    = 32'h500;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h0000_0BAD;
        sample();
        check("fl_drop_no_ready", 128'(if_ready_o), 128'(1'b0));
        check("fl_drop_stall", 128'(F_stall_req_o), 128'(1'b1));
        next_cycle();
        bus_rvalid_i = 1'b0;
        sample();
        check("fl_idle_bus_req", 128'(bus_req_o), 128'(1'b0));
        next_cycle();
        bus_gnt_i = 1'b1;
        sample();
        check("fl_refetch_cmd", 128'({bus_req_o, bus_addr_o}), 128'({1'b1, 32'h500}));
        next_cycle();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h0000_600D;
        sample();
        check("fl_refetch_ready", 128'(if_ready_o), 128'(1'b1));
        check("fl_refetch_rdata", 128'(if_rdata_o), 128'(32'h600D));
        next_cycle();
        bus_rvalid_i = 1'b0;
        if_req_i     = 1'b0;

        // ---------------- timeout in WAIT ----------------
        next_cycle();
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h3000;
        next_cycle();
        bus_gnt_i = 1'b1;
        sample();
        check("to_cmd", 128'({bus_req_o, bus_addr_o}), 128'({1'b1, 32'h3000}));
        next_cycle();
        bus_gnt_i  = 1'b0;
        ready_seen = 1'b0;
        for (int i = 0; i < 255; i++) begin
            sample();
            ready_seen = ready_seen | mem_ready_o;
            if (i == 254) check("to_err_before_limit", 128'(err_o), 128'(1'b0));
            next_cycle();
        end
        sample();
        check("to_err_set", 128'(err_o), 128'(1'b1));
        check("to_stall_held", 128'(M_stall_req_o), 128'(1'b1));
        check("to_no_ready", 128'(ready_seen | mem_ready_o), 128'(1'b0));
        repeat (10) next_cycle();
        sample();
        check("to_err_sticky", 128'(err_o), 128'(1'b1));
        check("to_stall_sticky", 128'(M_stall_req_o), 128'(1'b1));

        // ---------------- asynchronous reset in WAIT ----------------
        next_cycle();
        bus_gnt_i = 1'b1;
        next_cycle();
        bus_gnt_i = 1'b0;
        #2;
        rst_n     = 1'b0;
        mem_req_i = 1'b0;
        #1;
        check("ar_err_cleared", 128'(err_o), 128'(1'b0));
        check("ar_bus_fields",
              128'({bus_req_o, bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o}), 128'(0));
        check("ar_outputs", 128'({if_ready_o, mem_ready_o, F_stall_req_o, M_stall_req_o}),
              128'(4'b0000));
        sample();
        rst_n = 1'b1;
        next_cycle();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hFFFF_FFFF;
        sample();
        check("ar_stray_rvalid", 128'({if_ready_o, mem_ready_o}), 128'(2'b00));
        next_cycle();
        bus_rvalid_i = 1'b0;
        sample();
        check("ar_stays_idle", 128'({bus_req_o, err_o}), 128'(2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
